// File: rtl/pipe_skid_stage_pkg.sv
// Shared types and helpers for the elastic pipeline stage (package pipe_pkg).
// Holds the slice state encoding, stats width and small pure helper functions.
package pipe_pkg;

  typedef enum logic [1:0] {
    SLICE_EMPTY = 2'd0,
    SLICE_ONE   = 2'd1,
    SLICE_FULL  = 2'd2
  } slice_st_e;

  localparam int STAT_W = 32;

  // Beats held by a slice in a given state.
  function automatic logic [1:0] slice_occupancy(input slice_st_e st);
    logic [1:0] occ;
    case (st)
      SLICE_ONE:  occ = 2'd1;
      SLICE_FULL: occ = 2'd2;
      default:    occ = 2'd0;
    endcase
    return occ;
  endfunction

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Valid/ready beat channel carrying one packed stage bundle.
// The master drives valid/data, the slave drives ready.
interface pipe_skid_stage_if #(
  parameter int DATA_W = 32
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/pipe_skid_stage_skid.sv
// One skid slice: main + skid register, registered upstream ready, flushable.
// Chained by pipe_skid_stage to build a DEPTH-deep elastic register.
module pipe_skid_slice
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] FLUSH_DATA = '0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic [1:0]        occ
);

  slice_st_e         state_reg;
  slice_st_e         state_next;
  logic [DATA_W-1:0] main_reg;
  logic [DATA_W-1:0] main_next;
  logic [DATA_W-1:0] skid_reg;
  logic [DATA_W-1:0] skid_next;
  logic              ready_reg;
  logic              up_fire;
  logic              dn_fire;

  assign up_ready = ready_reg;
  assign up_fire  = up_valid & ready_reg;
  assign dn_valid = (state_reg != SLICE_EMPTY);
  assign dn_fire  = dn_valid & dn_ready;
  assign dn_data  = main_reg;
  assign occ      = slice_occupancy(state_reg);

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    if (flush) begin
      // A beat handshaken this cycle is swallowed along with the contents.
      state_next = SLICE_EMPTY;
      main_next  = FLUSH_DATA;
      skid_next  = FLUSH_DATA;
    end else begin
      case (state_reg)
        SLICE_EMPTY: begin
          if (up_fire) begin
            state_next = SLICE_ONE;
            main_next  = up_data;
          end
        end
        SLICE_ONE: begin
          if (up_fire && dn_fire) begin
            main_next = up_data;
          end else if (up_fire) begin
            state_next = SLICE_FULL;
            skid_next  = up_data;
          end else if (dn_fire) begin
            state_next = SLICE_EMPTY;
          end
        end
        SLICE_FULL: begin
          if (dn_fire) begin
            state_next = SLICE_ONE;
            main_next  = skid_reg;
          end
        end
        default: begin
          state_next = SLICE_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg <= SLICE_EMPTY;
      main_reg  <= FLUSH_DATA;
      skid_reg  <= FLUSH_DATA;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
      skid_reg  <= skid_next;
      // Ready comes straight from a flop, so nothing downstream reaches it combinationally.
      ready_reg <= (state_next != SLICE_FULL);
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline register: DEPTH chained skid slices, full throughput, flush.
// Optional stall/flush statistics counters are built when PIPE_STATS_EN is defined.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter int                DEPTH      = 1,
  parameter logic [DATA_W-1:0] FLUSH_DATA = '0
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic                             i_flush,
  pipe_skid_stage_if.slave                 up,
  pipe_skid_stage_if.master                dn,
  output logic [$clog2(2*DEPTH+1)-1:0]     o_count,
  output logic [STAT_W-1:0]                o_stall_cnt,
  output logic [STAT_W-1:0]                o_flush_cnt
);

  localparam int CNT_W = $clog2(2*DEPTH+1);

  logic [DEPTH:0]        link_valid;
  logic [DEPTH:0]        link_ready;
  logic [DATA_W-1:0]     link_data [DEPTH+1];
  logic [DEPTH-1:0][1:0] slice_occ;
  logic [CNT_W-1:0]      count_sum;

  assign link_valid[0]     = up.valid;
  assign link_data[0]      = up.data;
  assign up.ready          = link_ready[0] & ~i_reset;
  assign link_ready[DEPTH] = dn.ready;
  assign dn.valid          = link_valid[DEPTH];
  assign dn.data           = link_data[DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slice
      pipe_skid_slice #(
        .DATA_W     (DATA_W),
        .FLUSH_DATA (FLUSH_DATA)
      ) u_slice (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .flush    (i_flush),
        .up_valid (link_valid[gi]),
        .up_ready (link_ready[gi]),
        .up_data  (link_data[gi]),
        .dn_valid (link_valid[gi+1]),
        .dn_ready (link_ready[gi+1]),
        .dn_data  (link_data[gi+1]),
        .occ      (slice_occ[gi])
      );
    end
  endgenerate

  always_comb begin
    count_sum = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_sum = count_sum + CNT_W'(slice_occ[i]);
    end
  end

  assign o_count = count_sum;

`ifdef PIPE_STATS_EN
  logic [STAT_W-1:0] stall_cnt_reg;
  logic [STAT_W-1:0] flush_cnt_reg;

  // Reset clears the stats; flush only bumps its own counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (dn.valid && !dn.ready) begin
        stall_cnt_reg <= sat_inc(stall_cnt_reg);
      end
      if (i_flush) begin
        flush_cnt_reg <= sat_inc(flush_cnt_reg);
      end
    end
  end

  assign o_stall_cnt = stall_cnt_reg;
  assign o_flush_cnt = flush_cnt_reg;
`else
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed self-checking bench for pipe_skid_stage at DEPTH 1, 2 and 3.
// Expected stats values follow whether PIPE_STATS_EN is defined for the build.
module tb_pipe_skid_stage;
  import pipe_pkg::*;

`ifdef PIPE_STATS_EN
  localparam logic [31:0] EXP_STALL = 32'd5;
  localparam logic [31:0] EXP_FLUSH = 32'd2;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
  localparam logic [31:0] EXP_FLUSH = 32'd0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic f1 = 1'b0;
  logic f2 = 1'b0;
  logic f3 = 1'b0;

  always #5 clk = ~clk;

  pipe_skid_stage_if #(.DATA_W(32)) up1 ();
  pipe_skid_stage_if #(.DATA_W(32)) dn1 ();
  pipe_skid_stage_if #(.DATA_W(32)) up2 ();
  pipe_skid_stage_if #(.DATA_W(32)) dn2 ();
  pipe_skid_stage_if #(.DATA_W(32)) up3 ();
  pipe_skid_stage_if #(.DATA_W(32)) dn3 ();

  logic [1:0]  cnt1;
  logic [2:0]  cnt2;
  logic [2:0]  cnt3;
  logic [31:0] st1, fl1, st2, fl2, st3, fl3;

  pipe_skid_stage #(.DATA_W(32), .DEPTH(1), .FLUSH_DATA(32'h0000_0013)) u1 (
    .i_clk(clk), .i_reset(rst), .i_flush(f1), .up(up1), .dn(dn1),
    .o_count(cnt1), .o_stall_cnt(st1), .o_flush_cnt(fl1)
  );
  pipe_skid_stage #(.DATA_W(32), .DEPTH(2), .FLUSH_DATA(32'h0)) u2 (
    .i_clk(clk), .i_reset(rst), .i_flush(f2), .up(up2), .dn(dn2),
    .o_count(cnt2), .o_stall_cnt(st2), .o_flush_cnt(fl2)
  );
  pipe_skid_stage #(.DATA_W(32), .DEPTH(3), .FLUSH_DATA(32'h0)) u3 (
    .i_clk(clk), .i_reset(rst), .i_flush(f3), .up(up3), .dn(dn3),
    .o_count(cnt3), .o_stall_cnt(st3), .o_flush_cnt(fl3)
  );

  int total = 0;
  int bad   = 0;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    up1.valid = 1'b0; up2.valid = 1'b0; up3.valid = 1'b0;
    f1 = 1'b0; f2 = 1'b0; f3 = 1'b0;
    step; step;
    rst = 1'b0;
    step;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    up1.valid = 1'b1;
    up1.data  = 32'hAA;
    for (int c = 0; c < 3; c++) begin
      step;
      total++; if (dn1.valid !== 1'b0) begin bad++; $display("FAIL reset_valid c%0d: got %b want 0", c, dn1.valid); end
      total++; if (dn1.data !== 32'h13) begin bad++; $display("FAIL reset_data c%0d: got %h want 00000013", c, dn1.data); end
      total++; if (up1.ready !== 1'b0) begin bad++; $display("FAIL reset_ready c%0d: got %b want 0", c, up1.ready); end
      total++; if (cnt1 !== 2'd0) begin bad++; $display("FAIL reset_count c%0d: got %0d want 0", c, cnt1); end
    end
    total++; if (st1 !== 32'd0 || fl1 !== 32'd0) begin bad++; $display("FAIL reset_stats: got %0d/%0d want 0/0", st1, fl1); end
    rst = 1'b0;
    up1.valid = 1'b0;
    total++; if (up1.ready !== 1'b0) begin bad++; $display("FAIL release_ready_same: got %b want 0", up1.ready); end
    step;
    total++; if (up1.ready !== 1'b1) begin bad++; $display("FAIL release_ready_next: got %b want 1", up1.ready); end
    total++; if (dn1.valid !== 1'b0) begin bad++; $display("FAIL release_valid: got %b want 0", dn1.valid); end
    $display("test_reset: reset held 3 cycles, ready after release");
  endtask

  task automatic test_stream;
    do_reset;
    dn3.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      up3.valid = (i < 4);
      up3.data  = 32'h10 + 32'(i);
      if (i < 4) begin
        total++; if (up3.ready !== 1'b1) begin bad++; $display("FAIL stream_ready e%0d: got %b want 1", i, up3.ready); end
      end
      step;
      if (i >= 2 && i <= 5) begin
        total++; if (dn3.valid !== 1'b1) begin bad++; $display("FAIL stream_valid e%0d: got %b want 1", i, dn3.valid); end
        total++; if (dn3.data !== 32'h10 + 32'(i - 2)) begin bad++; $display("FAIL stream_data e%0d: got %h want %h", i, dn3.data, 32'h10 + 32'(i - 2)); end
        $display("stream: out %h after edge %0d", dn3.data, i);
      end else begin
        total++; if (dn3.valid !== 1'b0) begin bad++; $display("FAIL stream_bubble e%0d: got %b want 0", i, dn3.valid); end
      end
      if (i == 3) begin
        total++; if (cnt3 !== 3'd3) begin bad++; $display("FAIL stream_count: got %0d want 3", cnt3); end
      end
      if (i == 7) up3.valid = 1'b0;
    end
  endtask

  task automatic test_backpressure;
    do_reset;
    dn1.ready = 1'b0;
    up1.valid = 1'b1; up1.data = 32'hA1;
    step;
    total++; if (cnt1 !== 2'd1 || up1.ready !== 1'b1) begin bad++; $display("FAIL bp_one: count %0d ready %b want 1/1", cnt1, up1.ready); end
    up1.data = 32'hB2;
    step;
    total++; if (cnt1 !== 2'd2) begin bad++; $display("FAIL bp_count_full: got %0d want 2", cnt1); end
    total++; if (up1.ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full: got %b want 0", up1.ready); end
    up1.data = 32'hC3;
    step;
    total++; if (cnt1 !== 2'd2 || dn1.data !== 32'hA1 || dn1.valid !== 1'b1) begin bad++; $display("FAIL bp_hold: count %0d data %h valid %b want 2/a1/1", cnt1, dn1.data, dn1.valid); end
    dn1.ready = 1'b1;
    step;
    $display("backpressure: out a1, now %h", dn1.data);
    total++; if (dn1.data !== 32'hB2 || cnt1 !== 2'd1 || up1.ready !== 1'b1) begin bad++; $display("FAIL bp_drain_b: data %h count %0d ready %b want b2/1/1", dn1.data, cnt1, up1.ready); end
    step;
    up1.valid = 1'b0;
    $display("backpressure: out b2, now %h", dn1.data);
    total++; if (dn1.data !== 32'hC3 || cnt1 !== 2'd1 || dn1.valid !== 1'b1) begin bad++; $display("FAIL bp_drain_c: data %h count %0d valid %b want c3/1/1", dn1.data, cnt1, dn1.valid); end
    step;
    total++; if (dn1.valid !== 1'b0 || cnt1 !== 2'd0) begin bad++; $display("FAIL bp_empty: valid %b count %0d want 0/0", dn1.valid, cnt1); end
  endtask

  task automatic test_flush;
    do_reset;
    dn2.ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      up2.valid = 1'b1; up2.data = 32'h1 + 32'(i);
      step;
    end
    total++; if (cnt2 !== 3'd4 || up2.ready !== 1'b0) begin bad++; $display("FAIL flush_fill: count %0d ready %b want 4/0", cnt2, up2.ready); end
    f2 = 1'b1; up2.data = 32'hDEAD;
    step;
    f2 = 1'b0; up2.valid = 1'b0;
    total++; if (dn2.valid !== 1'b0 || cnt2 !== 3'd0) begin bad++; $display("FAIL flush_clear: valid %b count %0d want 0/0", dn2.valid, cnt2); end
    total++; if (up2.ready !== 1'b1 || dn2.data !== 32'h0) begin bad++; $display("FAIL flush_ready_data: ready %b data %h want 1/0", up2.ready, dn2.data); end
    // Flush while a beat is actually handshaken: that beat must vanish too.
    dn2.ready = 1'b1;
    up2.valid = 1'b1; up2.data = 32'hBEEF; f2 = 1'b1;
    step;
    f2 = 1'b0; up2.valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step;
      total++; if (dn2.valid !== 1'b0) begin bad++; $display("FAIL flush_leak c%0d: valid %b data %h want 0", c, dn2.valid, dn2.data); end
    end
    up2.valid = 1'b1; up2.data = 32'h55;
    step;
    up2.valid = 1'b0;
    step;
    $display("flush: post-flush beat out %h", dn2.data);
    total++; if (dn2.valid !== 1'b1 || dn2.data !== 32'h55) begin bad++; $display("FAIL flush_recover: valid %b data %h want 1/55", dn2.valid, dn2.data); end
  endtask

  task automatic test_simultaneous;
    do_reset;
    dn1.ready = 1'b1;
    up1.valid = 1'b1; up1.data = 32'h100;
    step;
    for (int i = 0; i < 10; i++) begin
      up1.data = 32'h101 + 32'(i);
      step;
      total++; if (cnt1 !== 2'd1 || up1.ready !== 1'b1) begin bad++; $display("FAIL simul_level c%0d: count %0d ready %b want 1/1", i, cnt1, up1.ready); end
      total++; if (dn1.data !== 32'h101 + 32'(i)) begin bad++; $display("FAIL simul_data c%0d: got %h want %h", i, dn1.data, 32'h101 + 32'(i)); end
    end
    up1.valid = 1'b0;
    step;
  endtask

  task automatic test_stats;
    do_reset;
    dn1.ready = 1'b0;
    up1.valid = 1'b1; up1.data = 32'h77;
    step;
    up1.valid = 1'b0;
    repeat (5) step;
    total++; if (st1 !== EXP_STALL) begin bad++; $display("FAIL stats_stall: got %0d want %0d", st1, EXP_STALL); end
    dn1.ready = 1'b1;
    step;
    f1 = 1'b1; step;
    f1 = 1'b0; step;
    f1 = 1'b1; step;
    f1 = 1'b0;
    total++; if (fl1 !== EXP_FLUSH) begin bad++; $display("FAIL stats_flush: got %0d want %0d", fl1, EXP_FLUSH); end
    total++; if (st1 !== EXP_STALL) begin bad++; $display("FAIL stats_stall_hold: got %0d want %0d", st1, EXP_STALL); end
    total++; if (dn1.data !== 32'h13 || cnt1 !== 2'd0) begin bad++; $display("FAIL stats_flush_data: data %h count %0d want 13/0", dn1.data, cnt1); end
    do_reset;
    total++; if (st1 !== 32'd0 || fl1 !== 32'd0) begin bad++; $display("FAIL stats_reset: got %0d/%0d want 0/0", st1, fl1); end
    $display("stats: stall=%0d flush=%0d", EXP_STALL, EXP_FLUSH);
  endtask

  initial begin
    up1.valid = 1'b0; up1.data = '0; dn1.ready = 1'b0;
    up2.valid = 1'b0; up2.data = '0; dn2.ready = 1'b0;
    up3.valid = 1'b0; up3.data = '0; dn3.ready = 1'b0;
    test_reset;
    test_stream;
    test_backpressure;
    test_flush;
    test_simultaneous;
    test_stats;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
